// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM (Moore) with optional memory-ready
// handshake and illegal-opcode trap.
module mc_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcWr,
    output logic       pcWrCond,
    output logic       iorD,
    output logic       memRe,
    output logic       memWr,
    output logic       irWr,
    output logic       mem2reg,
    output logic       regDst,
    output logic       regWr,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluop,
    output logic [1:0] pcSrc,
    output logic       instr_done,
    output logic       bad_op,
    output logic       trap,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BEQ = 4'd8, JUMP = 4'd9,
        IADD = 4'd10, IOR = 4'd11, IWB = 4'd12, TRAP = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   is_load_q, is_load_d;
    logic   rdy;

    assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        pcWr       = 1'b0;
        pcWrCond   = 1'b0;
        iorD       = 1'b0;
        memRe      = 1'b0;
        memWr      = 1'b0;
        irWr       = 1'b0;
        mem2reg    = 1'b0;
        regDst     = 1'b0;
        regWr      = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluop      = 2'b00;
        pcSrc      = 2'b00;
        instr_done = 1'b0;
        bad_op     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                memRe   = 1'b1;
                aluSrcB = 2'b01;
                irWr    = rdy;
                pcWr    = rdy;
                state_d = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcB   = 2'b11;
                is_load_d = opcode == 6'b100011;
                case (opcode)
                    6'b000000:            state_d = EXEC;
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100:            state_d = BEQ;
                    6'b000010:            state_d = JUMP;
                    6'b001000:            state_d = IADD;
                    6'b001101:            state_d = IOR;
                    default: begin
                        bad_op     = 1'b1;
                        instr_done = !TRAP_ILLEGAL;
                        state_d    = TRAP_ILLEGAL ? TRAP : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = is_load_q ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRe   = 1'b1;
                iorD    = 1'b1;
                state_d = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regWr      = 1'b1;
                mem2reg    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                memWr      = 1'b1;
                iorD       = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? FETCH : MEMWR;
            end
            EXEC: begin
                aluSrcA = 1'b1;
                aluop   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                regWr      = 1'b1;
                regDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                aluSrcA    = 1'b1;
                aluop      = 2'b01;
                pcWrCond   = 1'b1;
                pcSrc      = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcWr       = 1'b1;
                pcSrc      = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            IADD, IOR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluop   = state_q == IOR ? 2'b11 : 2'b00;
                state_d = IWB;
            end
            IWB: begin
                regWr      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_d = FETCH;
        endcase
        // Reset silences every control combinationally, even the FETCH enables.
        if (rst) begin
            {pcWr, pcWrCond, iorD, memRe, memWr, irWr, mem2reg, regDst, regWr, aluSrcA} = '0;
            {aluSrcB, aluop, pcSrc, instr_done, bad_op, trap} = '0;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: instruction-level model of mc_control, checked every cycle on
// two instances (handshake+trap enabled, and both disabled).
module tb_mc_control;
    localparam logic [9:0] E_PCW = 10'h200, E_PCWC = 10'h100, E_IORD = 10'h080, E_MRE = 10'h040,
                           E_MWR = 10'h020, E_IRW = 10'h010, E_M2R = 10'h008, E_RDST = 10'h004,
                           E_RGW = 10'h002, E_ASA = 10'h001;

    typedef struct packed {
        logic        sel;
        logic [5:0]  op;
        logic        rdy;
        logic [22:0] exp;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [5:0] opcode [2];
    logic       mem_ready [2];
    logic       pc_wr [2], pc_wr_cond [2], ior_d [2], mem_re [2], mem_wr [2], ir_wr [2];
    logic       mem2reg [2], reg_dst [2], reg_wr [2], alu_src_a [2];
    logic [1:0] alu_src_b [2], aluop [2], pc_src [2];
    logic       instr_done [2], bad_op [2], trap [2];
    logic [3:0] state [2];
    logic [22:0] obs [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_control #(.MEM_HANDSHAKE(g == 1), .TRAP_ILLEGAL(g == 1)) dut (
            .clk(clk), .rst(rst[g]), .opcode(opcode[g]), .mem_ready(mem_ready[g]),
            .pcWr(pc_wr[g]), .pcWrCond(pc_wr_cond[g]), .iorD(ior_d[g]), .memRe(mem_re[g]),
            .memWr(mem_wr[g]), .irWr(ir_wr[g]), .mem2reg(mem2reg[g]), .regDst(reg_dst[g]),
            .regWr(reg_wr[g]), .aluSrcA(alu_src_a[g]), .aluSrcB(alu_src_b[g]), .aluop(aluop[g]),
            .pcSrc(pc_src[g]), .instr_done(instr_done[g]), .bad_op(bad_op[g]), .trap(trap[g]),
            .state(state[g])
        );
        assign obs[g] = {pc_wr[g], pc_wr_cond[g], ior_d[g], mem_re[g], mem_wr[g], ir_wr[g],
                         mem2reg[g], reg_dst[g], reg_wr[g], alu_src_a[g], alu_src_b[g],
                         aluop[g], pc_src[g], instr_done[g], bad_op[g], trap[g], state[g]};
    end

    int tests = 0, fails = 0;
    int cyc, n_mwr, n_irw, n_bad, n_trap;
    logic [31:0] done_pk, st_pk;
    rec_t q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [22:0] ev(input int st, input logic [9:0] en, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic [1:0] ps,
                                       input logic dn, input logic bd, input logic tp);
        return {en, sb, ao, ps, dn, bd, tp, 4'(st)};
    endfunction

    task automatic add(input int s, input logic [5:0] op, input logic rdy, input logic [22:0] e);
        q.push_back('{sel: 1'(s), op: op, rdy: rdy, exp: e});
    endtask

    // One instruction as a list of cycles; op2 is driven once DECODE has passed.
    task automatic insn(input int s, input logic [5:0] op, input int fw, input int mw,
                        input logic [5:0] op2);
        logic r1, known;
        r1 = s == 1;
        known = op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0d};
        for (int i = 0; i < fw; i++) add(s, op, 1'b0, ev(0, E_MRE, 2'b01, 0, 0, 0, 0, 0));
        add(s, op, r1, ev(0, E_MRE | E_IRW | E_PCW, 2'b01, 0, 0, 0, 0, 0));
        add(s, op, 1'b0, ev(1, 0, 2'b11, 0, 0, !known && s == 0, !known, 0));
        case (op)
            6'h23, 6'h2b: begin
                add(s, op2, 1'b0, ev(2, E_ASA, 2'b10, 0, 0, 0, 0, 0));
                for (int i = 0; i < mw; i++)
                    add(s, op2, 1'b0, op == 6'h23 ? ev(3, E_MRE | E_IORD, 0, 0, 0, 0, 0, 0)
                                                  : ev(5, E_MWR | E_IORD, 0, 0, 0, 0, 0, 0));
                if (op == 6'h23) begin
                    add(s, op2, r1, ev(3, E_MRE | E_IORD, 0, 0, 0, 0, 0, 0));
                    add(s, op2, 1'b0, ev(4, E_RGW | E_M2R, 0, 0, 0, 1, 0, 0));
                end else add(s, op2, r1, ev(5, E_MWR | E_IORD, 0, 0, 0, 1, 0, 0));
            end
            6'h00: begin
                add(s, op2, 1'b0, ev(6, E_ASA, 0, 2'b10, 0, 0, 0, 0));
                add(s, op2, 1'b1, ev(7, E_RGW | E_RDST, 0, 0, 0, 1, 0, 0));
            end
            6'h04: add(s, op2, 1'b0, ev(8, E_ASA | E_PCWC, 0, 2'b01, 2'b01, 1, 0, 0));
            6'h02: add(s, op2, 1'b1, ev(9, E_PCW, 0, 0, 2'b10, 1, 0, 0));
            6'h08, 6'h0d: begin
                add(s, op2, 1'b0, ev(op == 6'h08 ? 10 : 11, E_ASA, 2'b10,
                                     op == 6'h08 ? 2'b00 : 2'b11, 0, 0, 0, 0));
                add(s, op2, 1'b0, ev(12, E_RGW, 0, 0, 0, 1, 0, 0));
            end
            default: ;
        endcase
    endtask

    task automatic run();
        rec_t r;
        logic [22:0] g;
        cyc = 0; done_pk = 0; st_pk = 0; n_mwr = 0; n_irw = 0; n_bad = 0; n_trap = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            opcode[r.sel] = r.op;
            mem_ready[r.sel] = r.rdy;
            #1;
            g = obs[r.sel];
            cyc++;
            chk($sformatf("dut%0d_cyc%0d", r.sel, cyc), 32'(g), 32'(r.exp));
            chk("idle_in_rst", 32'(obs[!r.sel]), 32'h0);
            if (g[6]) done_pk = {done_pk[23:0], 8'(cyc)};
            st_pk = {st_pk[27:0], g[3:0]};
            n_mwr += int'(g[18]);
            n_irw += int'(g[17]);
            n_bad += int'(g[5]);
            n_trap += int'(g[4]);
            @(negedge clk);
        end
    endtask

    initial begin
        logic found;
        rst[0] = 1'b1; rst[1] = 1'b1;
        opcode[0] = '0; opcode[1] = '0;
        mem_ready[0] = 1'b0; mem_ready[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_d1", 32'(obs[1]), 32'h0);
        chk("rst_d0", 32'(obs[0]), 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        insn(1, 6'h23, 0, 0, 6'h2b);
        run();
        chk("lw_done", done_pk, 32'h05);
        chk("lw_states", st_pk, 32'h01234);
        insn(1, 6'h2b, 3, 2, 6'h2b);
        run();
        chk("sw_done", done_pk, 32'h09);
        chk("sw_memwr_cycles", 32'(n_mwr), 32'd3);
        chk("sw_irwr_cycles", 32'(n_irw), 32'd1);
        insn(1, 6'h0d, 0, 0, 6'h0d);
        insn(1, 6'h08, 0, 0, 6'h08);
        insn(1, 6'h02, 0, 0, 6'h02);
        run();
        chk("ori_addi_j_done", done_pk, 32'h0004080b);
        insn(1, 6'h04, 1, 0, 6'h04);
        insn(1, 6'h00, 0, 0, 6'h3f);
        run();
        chk("beq_r_done", done_pk, 32'h0408);
        opcode[1] = 6'h2b;
        mem_ready[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (obs[1][3:0] == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_memwr", 32'(found), 32'h1);
        mem_ready[1] = 1'b0;
        #1 chk("memwr_on", 32'(obs[1][18]), 32'h1);
        rst[1] = 1'b1;
        #1 chk("rst_async", 32'(obs[1]), 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        #1 chk("post_rst_fetch", 32'(obs[1]), 32'(ev(0, E_MRE, 2'b01, 0, 0, 0, 0, 0)));
        insn(1, 6'h3f, 0, 0, 6'h3f);
        for (int i = 0; i < 20; i++) add(1, 6'h3f, i[0], ev(15, 0, 0, 0, 0, 0, 0, 1));
        run();
        chk("trap_bad_pulses", 32'(n_bad), 32'd1);
        chk("trap_cycles", 32'(n_trap), 32'd20);
        chk("trap_no_done", done_pk, 32'h0);
        rst[1] = 1'b1;
        #1 chk("trap_rst", 32'(obs[1]), 32'h0);
        rst[0] = 1'b0;
        insn(0, 6'h3f, 0, 0, 6'h3f);
        insn(0, 6'h00, 0, 0, 6'h00);
        run();
        chk("nop_r_done", done_pk, 32'h0206);
        chk("nop_bad_pulses", 32'(n_bad), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the MIPS datapath: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-memory/shared-ALU datapath. It decodes the same opcode set as the single-cycle decoder (R-type, lw, sw, beq, j, addi, ori). It adds:
- an optional memory ready handshake;
- an OR-immediate ALU mode;
- illegal-opcode detection with an optional sticky trap.

It sits between the instruction register opcode field and the multicycle datapath enables.

## Interface
- MEM_HANDSHAKE, 1, 1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready is ignored and treated as 1.
- TRAP_ILLEGAL, 1, 1: an illegal opcode enters sticky TRAP; 0: it is treated as a NOP and returns to FETCH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26]; sampled in DECODE only.
- mem_ready  in  1  memory access completes this cycle.
- pcWr, pcWrCond, iorD, memRe, memWr, irWr, mem2reg, regDst, regWr, aluSrcA  out  1 each  datapath controls.
- aluSrcB  out  2  00 = B reg, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- aluop  out  2  00 = add, 01 = sub, 10 = funct field, 11 = OR (zero-ext imm).
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- bad_op  out  1  one-cycle pulse in DECODE for an unknown opcode.
- trap  out  1  high while in TRAP.
- state  out  4  current state, for debug.

## Operation
- State register is 4 bits. Encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BEQ = 8, JUMP = 9, IADD = 10, IOR = 11, IWB = 12, TRAP = 15.
  - Codes 13–14 are unreachable and recover to FETCH.
- `rdy` = mem_ready when MEM_HANDSHAKE = 1, else 1.
- Transitions:
  - FETCH → DECODE on rdy; else stay.
  - DECODE by opcode:
    - 000000 → EXEC
    - 100011 and 101011 → MEMADR
    - 000100 → BEQ
    - 000010 → JUMP
    - 001000 → IADD
    - 001101 → IOR
    - other → TRAP if TRAP_ILLEGAL, else FETCH.
  - MEMADR → MEMRD if opcode was lw, else MEMWR. This uses a 1-bit is_load flag latched in DECODE; opcode may change after DECODE.
  - MEMRD → MEMWB on rdy. MEMWR → FETCH on rdy.
  - EXEC → RWB. IADD, IOR → IWB.
  - MEMWB, RWB, IWB, BEQ, JUMP → FETCH.
  - TRAP → TRAP until rst.
- Outputs are Moore, decoded from state (only the rdy-gated ones depend on mem_ready). Any output not listed for a state is 0:
  - FETCH: memRe = 1, aluSrcB = 01, irWr = rdy, pcWr = rdy.
  - DECODE: aluSrcB = 11; bad_op as defined above.
  - MEMADR: aluSrcA = 1, aluSrcB = 10.
  - MEMRD: memRe = 1, iorD = 1.
  - MEMWB: regWr = 1, mem2reg = 1, instr_done = 1.
  - MEMWR: memWr = 1, iorD = 1, instr_done = rdy.
  - EXEC: aluSrcA = 1, aluop = 10.
  - RWB: regWr = 1, regDst = 1, instr_done = 1.
  - BEQ: aluSrcA = 1, aluop = 01, pcWrCond = 1, pcSrc = 01, instr_done = 1.
  - JUMP: pcWr = 1, pcSrc = 10, instr_done = 1.
  - IADD: aluSrcA = 1, aluSrcB = 10, aluop = 00.
  - IOR: aluSrcA = 1, aluSrcB = 10, aluop = 11.
  - IWB: regWr = 1, instr_done = 1.
  - TRAP: trap = 1.
  - With TRAP_ILLEGAL = 0, an illegal opcode gets instr_done = 1 in DECODE.

## Timing
- Reset:
  - While rst is high, state = FETCH (0), is_load = 0, and every output is forced to 0, including pcWr and irWr.
  - After release, the first rising edge begins a normal FETCH cycle.
  - Reset mid-instruction aborts it immediately; no write enable is asserted after rst rises.
- Cycle counts with rdy always 1:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j: 3
  - illegal with TRAP_ILLEGAL = 0: 2.
- Each wait cycle (rdy = 0) in FETCH, MEMRD or MEMWR adds exactly one cycle.
- During a wait, memRe/memWr and iorD stay stable; irWr, pcWr and instr_done stay 0.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- instr_done is high in exactly one cycle per instruction and never in two consecutive cycles.

## Test plan
- Reset while in MEMWR with memWr = 1 → memWr drops combinationally with rst; state = 0; after release FETCH has memRe = 1, aluSrcB = 01.
- lw (100011), mem_ready = 1 always → states 0, 1, 2, 3, 4, 0; regWr = mem2reg = 1 only in state 4; instr_done pulses at cycle 5.
- sw with mem_ready low for 3 cycles in FETCH and 2 in MEMWR → 4 + 5 = 9 cycles; irWr/pcWr high only on the FETCH cycle with mem_ready = 1; memWr high for 3 cycles.
- ori (001101), then addi (001000), then j (000010) → aluop 11 in IOR, 00 in IADD; regDst = 0 in IWB; pcSrc = 10 with pcWr = 1 in JUMP; done pulses at cycles 4, 8, 11.
- Opcode 111111 with TRAP_ILLEGAL = 1 → bad_op pulses in DECODE; state = 15; trap stays 1 and all enables stay 0 for 20 cycles, until rst.
- Same opcode with TRAP_ILLEGAL = 0 and MEM_HANDSHAKE = 0 → bad_op and instr_done in DECODE; FETCH follows; a subsequent R-type completes in 4 cycles with regDst = 1.
